// File: rtl/traffic_intersection_ctrl.sv
// Round-robin N-approach signal controller with pedestrian crossings, demand-driven
// early green termination and a whole-second countdown for the matrix display.
//
// state         | meaning
// S_IDLE        | disabled, all car yellows flash, pedestrian lamps dark
// S_ALL_RED     | clearance, every approach red
// S_RED_YELLOW  | active approach red+yellow
// S_GREEN       | active approach green, other crossings walk
// S_GREEN_BLINK | active green and walking crossings blink
// S_YELLOW      | active approach yellow
module traffic_intersection_ctrl #(
    parameter int N_PHASES      = 2,
    parameter int T_ALL_RED     = 10,
    parameter int T_RED_YELLOW  = 10,
    parameter int T_GREEN       = 150,
    parameter int T_GREEN_MIN   = 50,
    parameter int T_GREEN_BLINK = 40,
    parameter int T_YELLOW      = 30,
    parameter int BLINK_HALF    = 5
) (
    input  logic                clk_10Hz,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [N_PHASES-1:0] ped_req,
    output logic [N_PHASES-1:0] car_red,
    output logic [N_PHASES-1:0] car_yellow,
    output logic [N_PHASES-1:0] car_green,
    output logic [N_PHASES-1:0] ped_red,
    output logic [N_PHASES-1:0] ped_green,
    output logic [N_PHASES-1:0] ped_pending,
    output logic [1:0]          active_phase,
    output logic [3:0]          countdown,
    output logic                countdown_valid
);
    typedef enum logic [2:0] {
        S_IDLE, S_ALL_RED, S_RED_YELLOW, S_GREEN, S_GREEN_BLINK, S_YELLOW
    } state_t;

    localparam int T_FULL  = T_GREEN + T_GREEN_BLINK + T_YELLOW;
    localparam int T_EARLY = T_GREEN_BLINK + T_YELLOW;

    if (N_PHASES < 2 || N_PHASES > 4 || T_FULL > 999 ||
        T_ALL_RED < 1 || T_ALL_RED > 255 || T_RED_YELLOW < 1 || T_RED_YELLOW > 255 ||
        T_GREEN < 1 || T_GREEN > 255 || T_GREEN_MIN < 1 || T_GREEN_MIN > 255 ||
        T_GREEN_BLINK < 1 || T_GREEN_BLINK > 255 || T_YELLOW < 1 || T_YELLOW > 255 ||
        BLINK_HALF < 1 || BLINK_HALF > 255) begin : g_bad_params
        $error("traffic_intersection_ctrl: parameter out of range");
    end

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [1:0]            phase_q, phase_d;
    logic [N_PHASES-1:0]   pend_q, pend_d;
    logic                  blink_q, blink_d;
    logic [7:0]            bcnt_q, bcnt_d;
    logic [7:0]            secs_q, secs_d;
    logic [3:0]            tenths_q, tenths_d;

    logic [7:0]            t_last;
    logic [N_PHASES-1:0]   act_mask;
    logic [N_PHASES-1:0]   set_vec;
    logic                  early;
    logic                  cd_state;

    function automatic logic [11:0] dec_bcd(input logic [7:0] s, input logic [3:0] t);
        if (t != 4'd0)      return {s, t - 4'd1};
        else if (s != 8'd0) return {s - 8'd1, 4'd9};
        else                return 12'd0;
    endfunction

    always_ff @(posedge clk_10Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            phase_q  <= 2'd0;
            pend_q   <= '0;
            blink_q  <= 1'b0;
            bcnt_q   <= 8'd0;
            secs_q   <= 8'd0;
            tenths_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            pend_q   <= pend_d;
            blink_q  <= blink_d;
            bcnt_q   <= bcnt_d;
            secs_q   <= secs_d;
            tenths_q <= tenths_d;
        end
    end

    always_comb begin
        act_mask = '0;
        for (int i = 0; i < N_PHASES; i++) act_mask[i] = (phase_q == 2'(i));
    end

    always_comb begin
        case (state_q)
            S_ALL_RED:     t_last = 8'(T_ALL_RED - 1);
            S_RED_YELLOW:  t_last = 8'(T_RED_YELLOW - 1);
            S_GREEN:       t_last = 8'(T_GREEN - 1);
            S_GREEN_BLINK: t_last = 8'(T_GREEN_BLINK - 1);
            S_YELLOW:      t_last = 8'(T_YELLOW - 1);
            default:       t_last = 8'd0;
        endcase
    end

    // A request arriving on the decision tick itself may end green immediately.
    assign set_vec = pend_q | (ped_req & ped_red);
    assign early   = (state_q == S_GREEN) && |(set_vec & act_mask) &&
                     (cnt_q >= 8'(T_GREEN_MIN - 1));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q + 8'd1;
        pend_d  = set_vec;
        case (state_q)
            S_IDLE:        state_d = S_ALL_RED;
            S_ALL_RED:     if (cnt_q == t_last) state_d = S_RED_YELLOW;
            S_RED_YELLOW:  if (cnt_q == t_last) state_d = S_GREEN;
            S_GREEN:       if (cnt_q == t_last || early) state_d = S_GREEN_BLINK;
            S_GREEN_BLINK: if (cnt_q == t_last) state_d = S_YELLOW;
            S_YELLOW: begin
                if (cnt_q == t_last) begin
                    state_d = S_ALL_RED;
                    phase_d = (phase_q == 2'(N_PHASES - 1)) ? 2'd0 : phase_q + 2'd1;
                end
            end
            default:       state_d = S_IDLE;
        endcase
        if (state_d == S_GREEN && state_q != S_GREEN) pend_d = set_vec & act_mask;
        if (!enable) begin
            state_d = S_IDLE;
            phase_d = 2'd0;
            pend_d  = '0;
        end
        if (state_d != state_q || state_d == S_IDLE) cnt_d = 8'd0;
    end

    // Blink phase restarts dark on every entry into a blinking state.
    always_comb begin
        blink_d = 1'b0;
        bcnt_d  = 8'd0;
        if ((state_d == S_IDLE || state_d == S_GREEN_BLINK) && state_d == state_q) begin
            if (bcnt_q == 8'(BLINK_HALF - 1)) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
                bcnt_d  = bcnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        secs_d   = secs_q;
        tenths_d = tenths_q;
        if (state_q == S_RED_YELLOW && state_d == S_GREEN) begin
            secs_d   = 8'(T_FULL / 10);
            tenths_d = 4'(T_FULL % 10);
        end else if (state_q == S_GREEN && state_d == S_GREEN_BLINK) begin
            secs_d   = 8'(T_EARLY / 10);
            tenths_d = 4'(T_EARLY % 10);
        end
        if (state_d == S_GREEN || state_d == S_GREEN_BLINK || state_d == S_YELLOW)
            {secs_d, tenths_d} = dec_bcd(secs_d, tenths_d);
    end

    always_comb begin
        car_red    = '0;
        car_yellow = '0;
        car_green  = '0;
        ped_red    = '0;
        ped_green  = '0;
        if (state_q == S_IDLE) begin
            car_yellow = {N_PHASES{blink_q}};
        end else begin
            for (int i = 0; i < N_PHASES; i++) begin
                if (act_mask[i]) begin
                    ped_red[i] = 1'b1;
                    case (state_q)
                        S_ALL_RED:     car_red[i] = 1'b1;
                        S_RED_YELLOW: begin
                            car_red[i]    = 1'b1;
                            car_yellow[i] = 1'b1;
                        end
                        S_GREEN:       car_green[i] = 1'b1;
                        S_GREEN_BLINK: car_green[i] = blink_q;
                        default:       car_yellow[i] = 1'b1;
                    endcase
                end else begin
                    car_red[i] = 1'b1;
                    if (state_q == S_GREEN)            ped_green[i] = 1'b1;
                    else if (state_q == S_GREEN_BLINK) ped_green[i] = blink_q;
                    else                               ped_red[i]   = 1'b1;
                end
            end
        end
    end

    assign cd_state        = (state_q == S_GREEN) || (state_q == S_GREEN_BLINK) ||
                             (state_q == S_YELLOW);
    assign countdown_valid = cd_state && (secs_q < 8'd10);
    assign countdown       = countdown_valid ? secs_q[3:0] : 4'd0;
    assign ped_pending     = pend_q;
    assign active_phase    = phase_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench: 2-phase timeline against a time-based expectation, reset, early exit,
// idle flashing, and a 3-phase instance for rotation and request clearing.
module tb_traffic_intersection_ctrl;
    logic clk_10Hz = 1'b0;
    always #5 clk_10Hz = ~clk_10Hz;

    logic       rst_n, enable;
    logic [1:0] ped_req;
    logic [1:0] car_red, car_yellow, car_green, ped_red, ped_green, ped_pending;
    logic [1:0] active_phase;
    logic [3:0] countdown;
    logic       countdown_valid;

    logic       rst3_n, enable3;
    logic [2:0] ped_req3;
    logic [2:0] car_red3, car_yellow3, car_green3, ped_red3, ped_green3, ped_pending3;
    logic [1:0] active_phase3;
    logic [3:0] countdown3;
    logic       countdown_valid3;

    traffic_intersection_ctrl #(.N_PHASES(2)) dut (
        .clk_10Hz(clk_10Hz), .rst_n(rst_n), .enable(enable), .ped_req(ped_req),
        .car_red(car_red), .car_yellow(car_yellow), .car_green(car_green),
        .ped_red(ped_red), .ped_green(ped_green), .ped_pending(ped_pending),
        .active_phase(active_phase), .countdown(countdown),
        .countdown_valid(countdown_valid)
    );

    traffic_intersection_ctrl #(.N_PHASES(3)) dut3 (
        .clk_10Hz(clk_10Hz), .rst_n(rst3_n), .enable(enable3), .ped_req(ped_req3),
        .car_red(car_red3), .car_yellow(car_yellow3), .car_green(car_green3),
        .ped_red(ped_red3), .ped_green(ped_green3), .ped_pending(ped_pending3),
        .active_phase(active_phase3), .countdown(countdown3),
        .countdown_valid(countdown_valid3)
    );

    int n_chk = 0;
    int n_bad = 0;
    int t = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_10Hz);
        #1;
        t++;
    endtask

    function automatic logic [14:0] obs2();
        return {active_phase, car_red, car_yellow, car_green, ped_green,
                countdown_valid, countdown};
    endfunction

    // Expected 2-phase output at tick tt after reset release; 240-tick cycle per phase.
    function automatic void model2(input int tt, output logic [14:0] v,
                                   output logic [1:0] pr, output logic [1:0] prm);
        int u, p, rem;
        logic [1:0] cr, cy, cg, pg;
        logic bl, cv;
        logic [3:0] cd;
        u = (tt - 1) % 240;
        p = ((tt - 1) / 240) % 2;
        cr = 2'b11; cy = 2'b00; cg = 2'b00; pg = 2'b00;
        pr = 2'b11; prm = 2'b11; cv = 1'b0; cd = 4'd0;
        if (u < 10) begin
        end else if (u < 20) begin
            cy[p] = 1'b1;
        end else if (u < 170) begin
            cr[p] = 1'b0; cg[p] = 1'b1; pg[1-p] = 1'b1; pr[1-p] = 1'b0;
        end else if (u < 210) begin
            bl = (((u - 170) / 5) % 2) == 1;
            cr[p] = 1'b0; cg[p] = bl; pg[1-p] = bl; prm[1-p] = 1'b0;
        end else begin
            cr[p] = 1'b0; cy[p] = 1'b1;
        end
        if (u >= 20) begin
            rem = 239 - u;
            if (rem < 100) begin
                cv = 1'b1;
                cd = 4'(rem / 10);
            end
        end
        v = {2'(p), cr, cy, cg, pg, cv, cd};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] ev;
        logic [1:0]  epr, eprm;
        rst_n = 1'b0; enable = 1'b1; ped_req = 2'b00;
        rst3_n = 1'b0; enable3 = 1'b1; ped_req3 = 3'b000;
        repeat (3) @(posedge clk_10Hz);
        #1;
        chk("reset2", 32'({obs2(), ped_red, ped_pending}), 32'd0);
        rst_n = 1'b1;
        t = 0;

        // full two-phase rotation with no requests
        for (int k = 1; k <= 481; k++) begin
            tick();
            model2(t, ev, epr, eprm);
            chk($sformatf("timeline t=%0d", t), 32'(obs2()), 32'(ev));
            chk($sformatf("ped_red t=%0d", t), 32'(ped_red & eprm), 32'(epr & eprm));
            chk($sformatf("ped_excl t=%0d", t), 32'(ped_red & ped_green), 32'd0);
            chk($sformatf("pend t=%0d", t), 32'(ped_pending), 32'd0);
        end

        // asynchronous reset in the middle of green
        while (t < 540) tick();
        chk("mid green", 32'(car_green), 32'(2'b01));
        #2 rst_n = 1'b0;
        #1 chk("async reset", 32'({obs2(), ped_red, ped_pending}), 32'd0);
        rst_n = 1'b1;
        t = 0;
        tick();
        model2(1, ev, epr, eprm);
        chk("post reset all_red", 32'({obs2(), ped_red}), 32'({ev, 2'b11}));

        // early exit: request at green tick 10 -> exit after tick 49
        while (t < 31) tick();
        ped_req = 2'b01;
        tick();
        ped_req = 2'b00;
        chk("pend set", 32'(ped_pending), 32'(2'b01));
        while (t < 69) tick();
        chk("green t69", 32'(car_green), 32'(2'b01));
        tick();
        chk("green last", 32'({car_green, countdown_valid}), 32'({2'b01, 1'b0}));
        tick();
        chk("early blink", 32'({car_green, countdown_valid, countdown}), 32'({2'b00, 1'b1, 4'd6}));
        chk("pend held", 32'(ped_pending), 32'(2'b01));
        while (t < 110) tick();
        chk("blink end", 32'({car_green, car_yellow}), 32'({2'b01, 2'b00}));
        tick();
        chk("yellow start", 32'({car_green, car_yellow, countdown_valid, countdown}),
            32'({2'b00, 2'b01, 1'b1, 4'd2}));
        while (t < 140) tick();
        chk("yellow last", 32'({car_yellow, countdown_valid, countdown}), 32'({2'b01, 1'b1, 4'd0}));
        tick();
        chk("phase1 all_red", 32'({active_phase, car_red, countdown_valid}), 32'({2'd1, 2'b11, 1'b0}));
        while (t < 160) tick();
        chk("pend before green1", 32'(ped_pending), 32'(2'b01));
        tick();
        chk("green1 entry", 32'({ped_pending, car_green, ped_green}), 32'({2'b00, 2'b10, 2'b01}));

        // same-tick request at green tick 80 -> exit on that tick
        while (t < 481) tick();
        chk("t80 green", 32'({ped_pending, car_green, countdown_valid}), 32'({2'b00, 2'b01, 1'b0}));
        ped_req = 2'b01;
        tick();
        ped_req = 2'b00;
        chk("t80 exit", 32'({car_green, countdown_valid, countdown}), 32'({2'b00, 1'b1, 4'd6}));
        chk("t80 pend", 32'(ped_pending), 32'(2'b01));

        // enable dropped during green blink
        while (t < 490) tick();
        enable = 1'b0;
        tick();
        chk("idle entry", 32'({obs2(), ped_red, ped_pending}), 32'd0);
        while (t < 495) tick();
        chk("idle dark", 32'(car_yellow), 32'(2'b00));
        tick();
        chk("idle lit", 32'({car_yellow, ped_red, ped_green, car_red}), 32'({2'b11, 6'd0}));
        ped_req = 2'b11;
        while (t < 500) tick();
        chk("idle lit end", 32'({car_yellow, ped_pending}), 32'({2'b11, 2'b00}));
        ped_req = 2'b00;
        tick();
        chk("idle dark2", 32'(car_yellow), 32'(2'b00));
        while (t < 506) tick();
        chk("idle lit2", 32'(car_yellow), 32'(2'b11));

        // three-phase instance
        chk("reset3", 32'({car_red3, car_yellow3, car_green3, ped_red3, ped_green3,
                          ped_pending3, active_phase3, countdown_valid3, countdown3}), 32'd0);
        rst3_n = 1'b1;
        t = 0;
        tick();
        chk("p3 all_red", 32'({active_phase3, car_red3}), 32'({2'd0, 3'b111}));
        while (t < 240) tick();
        chk("p3 phase0 end", 32'(active_phase3), 32'd0);
        tick();
        chk("p3 phase1", 32'(active_phase3), 32'd1);
        while (t < 481) tick();
        chk("p3 phase2", 32'(active_phase3), 32'd2);
        while (t < 561) tick();
        chk("p3 green2", 32'({car_green3, ped_green3}), 32'({3'b100, 3'b011}));
        ped_req3 = 3'b100;
        tick();
        ped_req3 = 3'b000;
        chk("p3 latch", 32'({ped_pending3, car_green3, countdown_valid3, countdown3}),
            32'({3'b100, 3'b000, 1'b1, 4'd6}));
        while (t < 632) tick();
        chk("p3 wrap", 32'({active_phase3, ped_pending3}), 32'({2'd0, 3'b100}));
        while (t < 651) tick();
        chk("p3 pend before", 32'(ped_pending3), 32'(3'b100));
        ped_req3 = 3'b010;
        tick();
        ped_req3 = 3'b000;
        chk("p3 green0 clear", 32'({ped_pending3, car_green3}), 32'({3'b000, 3'b001}));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
